// File: rtl/mmu_rx_pkg.sv
// -----------------------------------------------------------------------------
// mmu_rx_pkg
//   Shared definitions for the mmu_rx read path: field positions of the 72-bit
//   rcmd FIFO command word, common widths, the splitter FSM state type and a
//   helper that assembles a command word.
//   No ports (package).
// -----------------------------------------------------------------------------
package mmu_rx_pkg;

  localparam int CMD_ADDR_W = 34;  // byte address width carried in a command
  localparam int ID_W       = 2;
  localparam int BD_LEN_W   = 16;  // BD byte length / remainder width
  localparam int CHUNK_W    = 14;  // chunk byte count field width
  localparam int CMD_W      = 72;

  localparam int ADDR_LSB = 0;
  localparam int ADDR_MSB = 33;
  localparam int ID_LSB   = 34;
  localparam int ID_MSB   = 35;
  localparam int LEN_LSB  = 36;
  localparam int LEN_MSB  = 49;
  localparam int ERR_POS  = 68;
  localparam int EOP_POS  = 69;
  localparam int LAST_POS = 70;

  typedef enum logic {
    IDLE  = 1'b0,
    SPLIT = 1'b1
  } split_state_e;

  // Every command is a single-word frame: eop=1, err=0, reserved bits zero.
  function automatic logic [CMD_W-1:0] pack_cmd(
    input logic [CMD_ADDR_W-1:0] addr,
    input logic [ID_W-1:0]       id,
    input logic [CHUNK_W-1:0]    bytes,
    input logic                  last
  );
    logic [CMD_W-1:0] w;
    w                   = '0;
    w[ADDR_MSB:ADDR_LSB] = addr;
    w[ID_MSB:ID_LSB]     = id;
    w[LEN_MSB:LEN_LSB]   = bytes;
    w[ERR_POS]           = 1'b0;
    w[EOP_POS]           = 1'b1;
    w[LAST_POS]          = last;
    return w;
  endfunction

endpackage

// File: rtl/axi4m_rd_cmd_split_if.sv
// -----------------------------------------------------------------------------
// axi4m_rd_cmd_split_if
//   Bus bundle between the BD source, the command splitter and the rcmd FIFO.
//   bd_valid/bd_ready/bd_addr/bd_len/bd_id : BD handshake and payload
//   rcmd_ff_full/rcmd_ff_wen/rcmd_ff_wdata : rcmd FIFO almost-full and write port
//   Modports:
//     slave  - the splitter (consumes BDs, writes commands)
//     master - the surroundings (issues BDs, owns the FIFO)
// -----------------------------------------------------------------------------
interface axi4m_rd_cmd_split_if;
  import mmu_rx_pkg::*;

  logic                  bd_valid;
  logic                  bd_ready;
  logic [CMD_ADDR_W-1:0] bd_addr;
  logic [BD_LEN_W-1:0]   bd_len;
  logic [ID_W-1:0]       bd_id;
  logic                  rcmd_ff_full;
  logic                  rcmd_ff_wen;
  logic [CMD_W-1:0]      rcmd_ff_wdata;

  modport slave (
    input  bd_valid, bd_addr, bd_len, bd_id, rcmd_ff_full,
    output bd_ready, rcmd_ff_wen, rcmd_ff_wdata
  );

  modport master (
    output bd_valid, bd_addr, bd_len, bd_id, rcmd_ff_full,
    input  bd_ready, rcmd_ff_wen, rcmd_ff_wdata
  );

endinterface

// File: rtl/axi4m_rd_chunk_calc.sv
// -----------------------------------------------------------------------------
// axi4m_rd_chunk_calc
//   Combinational size of the next chunk: the bytes left to the next
//   SPLIT_BYTES-aligned boundary, capped by the BD remainder.
//   ofs   in  offset of the current address inside its SPLIT_BYTES window
//   rem   in  bytes still to issue for the BD (>= 1 while splitting)
//   chunk out bytes of the next command, 1..SPLIT_BYTES
//   last  out this chunk finishes the BD
// -----------------------------------------------------------------------------
module axi4m_rd_chunk_calc
  import mmu_rx_pkg::*;
#(
  parameter int SPLIT_BYTES = 4096,
  parameter int OFS_W       = $clog2(SPLIT_BYTES)
) (
  input  logic [OFS_W-1:0]    ofs,
  input  logic [BD_LEN_W-1:0] rem,
  output logic [CHUNK_W-1:0]  chunk,
  output logic                last
);

  logic [BD_LEN_W-1:0] room;

  // room is 1..SPLIT_BYTES; a zero offset yields a full window.
  assign room  = BD_LEN_W'(SPLIT_BYTES) - BD_LEN_W'(ofs);
  assign last  = (rem <= room);
  // Whichever operand is selected is <= SPLIT_BYTES, so the cast never drops bits.
  assign chunk = last ? CHUNK_W'(rem) : CHUNK_W'(room);

endmodule

// File: rtl/axi4m_rd_cmd_split.sv
// -----------------------------------------------------------------------------
// axi4m_rd_cmd_split
//   Accepts one read buffer descriptor per handshake and splits it into
//   commands that never cross a SPLIT_BYTES-aligned boundary, writing one
//   72-bit word per chunk into the rcmd FIFO while its almost-full is low.
//   aclk            in   clock
//   areset          in   synchronous active-high reset
//   bus             if   slave modport: BD handshake + rcmd FIFO write port
//   reg_bd_len0_err out  sticky flag, a zero-length BD was dropped
//   reg_bd_cnt      out  BDs accepted (AXI4M_RD_CMD_SPLIT_STAT_EN only)
//   reg_cmd_cnt     out  command writes (AXI4M_RD_CMD_SPLIT_STAT_EN only)
//   Build option: define AXI4M_RD_CMD_SPLIT_STAT_EN to add the statistics
//   counters and their ports.
// -----------------------------------------------------------------------------
module axi4m_rd_cmd_split
  import mmu_rx_pkg::*;
#(
  parameter int SPLIT_BYTES = 4096,
  parameter int ADDR_W      = 34
) (
  input  logic                      aclk,
  input  logic                      areset,
  axi4m_rd_cmd_split_if.slave       bus,
  output logic                      reg_bd_len0_err
`ifdef AXI4M_RD_CMD_SPLIT_STAT_EN
  ,
  output logic [31:0]               reg_bd_cnt,
  output logic [31:0]               reg_cmd_cnt
`endif
);

  localparam int OFS_W = $clog2(SPLIT_BYTES);

  split_state_e        state_q, state_d;
  logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
  logic [BD_LEN_W-1:0] rem_q, rem_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic                wen_q, wen_d;
  logic [CMD_W-1:0]    wdata_q, wdata_d;
  logic                len0_err_q, len0_err_d;
  logic [CHUNK_W-1:0]  chunk;
  logic                last;
  logic                bd_fire;

  axi4m_rd_chunk_calc #(
    .SPLIT_BYTES (SPLIT_BYTES),
    .OFS_W       (OFS_W)
  ) u_chunk_calc (
    .ofs   (cur_addr_q[OFS_W-1:0]),
    .rem   (rem_q),
    .chunk (chunk),
    .last  (last)
  );

  // Ready depends on state only, never on bd_valid or the FIFO flag.
  assign bus.bd_ready = (state_q == IDLE) && !areset;
  assign bd_fire      = bus.bd_valid && bus.bd_ready;

  always_comb begin
    // NOTE: every target gets its hold value first, so no path can leave one
    // unassigned and infer a latch.
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    rem_d      = rem_q;
    id_d       = id_q;
    wen_d      = 1'b0;
    wdata_d    = wdata_q;
    len0_err_d = len0_err_q;

    unique case (state_q)
      IDLE: begin
        if (bd_fire) begin
          cur_addr_d = bus.bd_addr;
          rem_d      = bus.bd_len;
          id_d       = bus.bd_id;
          // A zero-length BD is swallowed: flag it and wait for the next one.
          if (bus.bd_len == '0) len0_err_d = 1'b1;
          else                  state_d    = SPLIT;
        end
      end
      SPLIT: begin
        // Almost-full leaves room for the one registered write still in flight.
        if (!bus.rcmd_ff_full) begin
          wen_d      = 1'b1;
          wdata_d    = pack_cmd(cur_addr_q, id_q, chunk, last);
          cur_addr_d = cur_addr_q + ADDR_W'(chunk);  // wraps silently
          rem_d      = rem_q - BD_LEN_W'(chunk);
          if (last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q    <= IDLE;
      cur_addr_q <= '0;
      rem_q      <= '0;
      id_q       <= '0;
      wen_q      <= 1'b0;
      wdata_q    <= '0;
      len0_err_q <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every register samples pre-edge values.
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      rem_q      <= rem_d;
      id_q       <= id_d;
      wen_q      <= wen_d;
      wdata_q    <= wdata_d;
      len0_err_q <= len0_err_d;
    end
  end

  assign bus.rcmd_ff_wen   = wen_q;
  assign bus.rcmd_ff_wdata = wdata_q;
  assign reg_bd_len0_err   = len0_err_q;

`ifdef AXI4M_RD_CMD_SPLIT_STAT_EN
  logic [31:0] bd_cnt_q;
  logic [31:0] cmd_cnt_q;

  // Both counters wrap at 2^32; zero-length BDs count as accepted.
  always_ff @(posedge aclk) begin
    if (areset) begin
      bd_cnt_q  <= '0;
      cmd_cnt_q <= '0;
    end else begin
      if (bd_fire) bd_cnt_q  <= bd_cnt_q + 32'd1;
      if (wen_q)   cmd_cnt_q <= cmd_cnt_q + 32'd1;
    end
  end

  assign reg_bd_cnt  = bd_cnt_q;
  assign reg_cmd_cnt = cmd_cnt_q;
`endif

endmodule

// File: tb/tb_axi4m_rd_cmd_split.sv
// -----------------------------------------------------------------------------
// tb_axi4m_rd_cmd_split
//   Self-checking bench for axi4m_rd_cmd_split. Expected command words come
//   from a plain arithmetic model of the splitting rule (distance to the next
//   4 KiB boundary, capped by the remainder, address modulo 2^34).
// -----------------------------------------------------------------------------
module tb_axi4m_rd_cmd_split;

  localparam int     SPLIT    = 4096;
  localparam longint ADDR_MOD = 64'h4_0000_0000;

  logic clk = 1'b0;
  logic areset = 1'b1;
  logic reg_bd_len0_err;
`ifdef AXI4M_RD_CMD_SPLIT_STAT_EN
  logic [31:0] reg_bd_cnt;
  logic [31:0] reg_cmd_cnt;
`endif

  int total = 0;
  int bad   = 0;
  int exp_bd_cnt  = 0;
  int exp_cmd_cnt = 0;

  logic [71:0] exp_q[$];

  axi4m_rd_cmd_split_if bus ();

  axi4m_rd_cmd_split #(
    .SPLIT_BYTES (SPLIT),
    .ADDR_W      (34)
  ) dut (
    .aclk            (clk),
    .areset          (areset),
    .bus             (bus),
    .reg_bd_len0_err (reg_bd_len0_err)
`ifdef AXI4M_RD_CMD_SPLIT_STAT_EN
    ,
    .reg_bd_cnt      (reg_bd_cnt),
    .reg_cmd_cnt     (reg_cmd_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Command word layout: {0, last, eop=1, err=0, 18'0, bytes, id, addr}.
  function automatic logic [71:0] exp_word(input longint a, input int bytes,
                                           input bit last, input logic [1:0] id);
    logic [33:0] a34;
    logic [13:0] b14;
    a34 = a[33:0];
    b14 = bytes[13:0];
    return {1'b0, last, 1'b1, 1'b0, 18'd0, b14, id, a34};
  endfunction

  task automatic model(input longint addr, input int len, input logic [1:0] id);
    longint a;
    int rem, room, c;
    a   = addr;
    rem = len;
    exp_q.delete();
    while (rem > 0) begin
      room = SPLIT - int'(a % SPLIT);
      c    = (rem < room) ? rem : room;
      exp_q.push_back(exp_word(a, c, (c == rem), id));
      a    = (a + c) % ADDR_MOD;
      rem  = rem - c;
    end
  endtask

  task automatic send_bd(input string name, input logic [33:0] addr, input int len,
                         input logic [1:0] id, output bit ok);
    int w;
    w = 0;
    while (bus.bd_ready !== 1'b1 && w < 50) begin
      tick();
      w++;
    end
    total++;
    ok = (bus.bd_ready === 1'b1);
    if (!ok) begin
      bad++;
      $display("FAIL %s bd_ready_wait: got %b want 1", name, bus.bd_ready);
      return;
    end
    bus.bd_valid = 1'b1;
    bus.bd_addr  = addr;
    bus.bd_len   = 16'(len);
    bus.bd_id    = id;
    tick();
    bus.bd_valid = 1'b0;
    exp_bd_cnt++;
  endtask

  // Send one BD and follow its commands to the last one. hold_at >= 0 raises
  // full for hold_len cycles once that many commands have been seen.
  task automatic run_bd(input string name, input logic [33:0] addr, input int len,
                        input logic [1:0] id, input int hold_at, input int hold_len,
                        input bit rand_full);
    logic [71:0] exp;
    int  k, first_k, seen, hold_left, full_wen;
    bit  ok, done, ready_bad, prev_full, hold_done;
    model(longint'(addr), len, id);
    send_bd(name, addr, len, id, ok);
    if (!ok) return;
    k = 0; first_k = 0; seen = 0; hold_left = 0; full_wen = 0;
    done = 0; ready_bad = 0; prev_full = 0; hold_done = 0;
    while (!done && k < 300) begin
      tick();
      k++;
      if (bus.rcmd_ff_wen === 1'b1) begin
        exp_cmd_cnt++;
        if (first_k == 0) first_k = k;
        if (prev_full) full_wen++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL %s extra_cmd: got %h want none", name, bus.rcmd_ff_wdata);
        end else begin
          exp = exp_q.pop_front();
          seen++;
          if (bus.rcmd_ff_wdata !== exp) begin
            bad++;
            $display("FAIL %s cmd%0d: got %h want %h", name, seen, bus.rcmd_ff_wdata, exp);
          end
          if (exp_q.size() == 0) begin
            done = 1;
            total++;
            if (bus.bd_ready !== 1'b1) begin
              bad++;
              $display("FAIL %s ready_after_last: got %b want 1", name, bus.bd_ready);
            end
          end
        end
      end
      if (!done && bus.bd_ready !== 1'b0) ready_bad = 1;
      if (done) begin
        bus.rcmd_ff_full = 1'b0;
      end else if (hold_left > 0) begin
        hold_left--;
        if (hold_left == 0) bus.rcmd_ff_full = 1'b0;
      end else if (!hold_done && hold_at >= 0 && seen == hold_at) begin
        bus.rcmd_ff_full = 1'b1;
        hold_left = hold_len;
        hold_done = 1;
      end else if (rand_full) begin
        bus.rcmd_ff_full = ($urandom_range(3) == 0);
      end
      prev_full = bus.rcmd_ff_full;
    end
    bus.rcmd_ff_full = 1'b0;
    total++;
    if (!done) begin
      bad++;
      $display("FAIL %s timeout: got %0d cmds want %0d more", name, seen, exp_q.size());
    end
    total++;
    if (first_k != 1) begin
      bad++;
      $display("FAIL %s latency: got first wen %0d cycles after accept+1 want 1", name, first_k);
    end
    total++;
    if (ready_bad) begin
      bad++;
      $display("FAIL %s ready_low: got bd_ready=1 while splitting want 0", name);
    end
    total++;
    if (full_wen != 0) begin
      bad++;
      $display("FAIL %s full_respected: got %0d writes after full want 0", name, full_wen);
    end
  endtask

  task automatic test_reset();
    areset = 1'b1;
    repeat (3) tick();
    total++;
    if (bus.rcmd_ff_wen !== 1'b0) begin
      bad++; $display("FAIL reset_wen: got %b want 0", bus.rcmd_ff_wen);
    end
    total++;
    if (bus.rcmd_ff_wdata !== 72'd0) begin
      bad++; $display("FAIL reset_wdata: got %h want 0", bus.rcmd_ff_wdata);
    end
    total++;
    if (reg_bd_len0_err !== 1'b0) begin
      bad++; $display("FAIL reset_err: got %b want 0", reg_bd_len0_err);
    end
    total++;
    if (bus.bd_ready !== 1'b0) begin
      bad++; $display("FAIL reset_ready_in_reset: got %b want 0", bus.bd_ready);
    end
    areset = 1'b0;
    tick();
    total++;
    if (bus.bd_ready !== 1'b1) begin
      bad++; $display("FAIL reset_ready_after: got %b want 1", bus.bd_ready);
    end
  endtask

  task automatic test_boundary();
    run_bd("boundary", 34'h0_0000_0F80, 'h200, 2'd1, -1, 0, 1'b0);
  endtask

  task automatic test_max_len();
    run_bd("max_len", 34'h0, 'hFFFF, 2'd3, -1, 0, 1'b0);
  endtask

  task automatic test_wrap();
    run_bd("wrap", 34'h3_FFFF_FFC0, 'h80, 2'd2, -1, 0, 1'b0);
  endtask

  task automatic test_full_hold();
    run_bd("full_hold", 34'h2_0000_0800, 'h4000, 2'd2, 2, 5, 1'b0);
  endtask

  task automatic test_len0();
    bit ok;
    int wens;
    send_bd("len0", 34'h1_0000_0040, 0, 2'd0, ok);
    if (!ok) return;
    total++;
    if (reg_bd_len0_err !== 1'b1) begin
      bad++; $display("FAIL len0_err: got %b want 1", reg_bd_len0_err);
    end
    total++;
    if (bus.bd_ready !== 1'b1) begin
      bad++; $display("FAIL len0_ready: got %b want 1", bus.bd_ready);
    end
    wens = (bus.rcmd_ff_wen === 1'b1) ? 1 : 0;
    repeat (3) begin
      tick();
      if (bus.rcmd_ff_wen === 1'b1) wens++;
    end
    total++;
    if (wens != 0) begin
      bad++; $display("FAIL len0_no_wen: got %0d writes want 0", wens);
    end
    run_bd("after_len0", 34'h0_1234_5F00, 'h300, 2'd1, -1, 0, 1'b0);
    total++;
    if (reg_bd_len0_err !== 1'b1) begin
      bad++; $display("FAIL len0_sticky: got %b want 1", reg_bd_len0_err);
    end
  endtask

  task automatic test_back_to_back();
    run_bd("b2b_0", 34'h0_0000_0FC0, 'h40,  2'd0, -1, 0, 1'b0);
    run_bd("b2b_1", 34'h0_0000_1000, 'h1,   2'd1, -1, 0, 1'b0);
    run_bd("b2b_2", 34'h0_0000_1FFF, 'h1001, 2'd2, -1, 0, 1'b0);
  endtask

  task automatic test_random();
    logic [63:0] r;
    logic [33:0] a;
    int len;
    for (int i = 0; i < 16; i++) begin
      r = {$urandom, $urandom};
      a = r[33:0];
      // Bias some start addresses to sit just below a boundary.
      if ($urandom_range(1) == 1) a[11:0] = 12'hFFF - 12'($urandom_range(127));
      len = ($urandom_range(3) == 0) ? $urandom_range(1, 64) : $urandom_range(1, 20000);
      run_bd($sformatf("rand%0d", i), a, len, 2'($urandom_range(3)), -1, 0, 1'b1);
    end
  endtask

  task automatic test_reset_mid();
    logic [71:0] exp;
    int k, seen, leftover;
    bit ok;
    model(64'h0, 'h5000, 2'd2);
    send_bd("reset_mid", 34'h0, 'h5000, 2'd2, ok);
    if (!ok) return;
    k = 0; seen = 0;
    while (seen < 2 && k < 20) begin
      tick();
      k++;
      if (bus.rcmd_ff_wen === 1'b1) begin
        exp = exp_q.pop_front();
        seen++;
        total++;
        if (bus.rcmd_ff_wdata !== exp) begin
          bad++; $display("FAIL reset_mid_cmd%0d: got %h want %h", seen, bus.rcmd_ff_wdata, exp);
        end
      end
    end
    total++;
    if (seen != 2) begin
      bad++; $display("FAIL reset_mid_pre: got %0d cmds want 2", seen);
    end
    // The third chunk is being issued in this cycle; reset must cancel it.
    areset = 1'b1;
    tick();
    exp_bd_cnt  = 0;
    exp_cmd_cnt = 0;
    total++;
    if (bus.rcmd_ff_wen !== 1'b0) begin
      bad++; $display("FAIL reset_mid_wen: got %b want 0", bus.rcmd_ff_wen);
    end
    total++;
    if (bus.rcmd_ff_wdata !== 72'd0) begin
      bad++; $display("FAIL reset_mid_wdata: got %h want 0", bus.rcmd_ff_wdata);
    end
    total++;
    if (reg_bd_len0_err !== 1'b0) begin
      bad++; $display("FAIL reset_mid_err: got %b want 0", reg_bd_len0_err);
    end
    areset = 1'b0;
    tick();
    total++;
    if (bus.bd_ready !== 1'b1) begin
      bad++; $display("FAIL reset_mid_ready: got %b want 1", bus.bd_ready);
    end
    leftover = 0;
    repeat (10) begin
      tick();
      if (bus.rcmd_ff_wen === 1'b1) leftover++;
    end
    total++;
    if (leftover != 0) begin
      bad++; $display("FAIL reset_mid_leftover: got %0d writes want 0", leftover);
    end
    run_bd("post_reset", 34'h0_0000_0F00, 'h1200, 2'd3, -1, 0, 1'b0);
  endtask

  task automatic test_stats();
`ifdef AXI4M_RD_CMD_SPLIT_STAT_EN
    repeat (3) tick();
    total++;
    if (reg_bd_cnt !== 32'(exp_bd_cnt)) begin
      bad++; $display("FAIL stat_bd_cnt: got %0d want %0d", reg_bd_cnt, exp_bd_cnt);
    end
    total++;
    if (reg_cmd_cnt !== 32'(exp_cmd_cnt)) begin
      bad++; $display("FAIL stat_cmd_cnt: got %0d want %0d", reg_cmd_cnt, exp_cmd_cnt);
    end
`else
    repeat (3) tick();
`endif
  endtask

  initial begin
    bus.bd_valid     = 1'b0;
    bus.bd_addr      = '0;
    bus.bd_len       = '0;
    bus.bd_id        = '0;
    bus.rcmd_ff_full = 1'b0;
    test_reset();
    test_boundary();
    test_max_len();
    test_wrap();
    test_full_hold();
    test_len0();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_stats();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
